// File: rtl/darksoc_rstseq.sv
// Reset sequencer: stretches XRES, then releases NCH reset channels in order, STAGGER cycles apart.
// Re-runs the sequence on soft-reset request or watchdog timeout and reports the last reset cause.
module darksoc_rstseq #(
    parameter int NCH         = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int STAGGER     = 2,
    parameter int WDT_LIMIT   = 1024
) (
    input  logic           XCLK,
    input  logic           XRES,
    input  logic           SWRST_REQ,
    input  logic           WDT_EN,
    input  logic           WDT_KICK,
    output logic [NCH-1:0] RST_OUT,
    output logic           READY,
    output logic [1:0]     CAUSE
);

    localparam int LAST = HOLD_CYCLES + (NCH - 1) * STAGGER;
    localparam int SW   = $clog2(LAST + 2);
    localparam int WW   = (WDT_LIMIT > 1) ? $clog2(WDT_LIMIT) : 1;

    localparam logic [SW-1:0] SEQ_MAX  = SW'(LAST + 1);
    localparam logic [WW-1:0] WDT_LAST = WW'((WDT_LIMIT > 0) ? WDT_LIMIT - 1 : 0);

    localparam logic [1:0] CAUSE_XRES = 2'b00;
    localparam logic [1:0] CAUSE_SOFT = 2'b01;
    localparam logic [1:0] CAUSE_WDT  = 2'b10;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  seq_q, seq_d;
    logic [WW-1:0]  wdt_q, wdt_d;
    logic [NCH-1:0] rst_q, rst_d;
    logic           ready_q, ready_d;
    logic [1:0]     cause_q, cause_d;
    logic           wdt_active;
    logic           wdt_timeout;

    always_ff @(posedge XCLK) begin
        if (XRES) begin
            state_q <= ST_ASSERT;
            seq_q   <= '0;
            wdt_q   <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            cause_q <= CAUSE_XRES;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            wdt_q   <= wdt_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        wdt_d       = '0;
        rst_d       = rst_q;
        ready_d     = ready_q;
        cause_d     = cause_q;
        wdt_active  = (WDT_LIMIT != 0) && WDT_EN && (state_q == ST_RUN);
        // A kick on the timeout edge wins over the timeout.
        wdt_timeout = wdt_active && !WDT_KICK && (wdt_q == WDT_LAST);

        if (SWRST_REQ || wdt_timeout) begin
            state_d = ST_ASSERT;
            seq_d   = '0;
            rst_d   = '1;
            ready_d = 1'b0;
            cause_d = SWRST_REQ ? CAUSE_SOFT : CAUSE_WDT;
        end else begin
            seq_d = (seq_q == SEQ_MAX) ? seq_q : seq_q + 1'b1;
            for (int k = 0; k < NCH; k++) begin
                rst_d[k] = int'(seq_d) < (HOLD_CYCLES + k * STAGGER);
            end
            ready_d = (seq_d == SEQ_MAX);
            if (ready_d) begin
                state_d = ST_RUN;
            end else if (int'(seq_d) < HOLD_CYCLES) begin
                state_d = ST_ASSERT;
            end else begin
                state_d = ST_RELEASE;
            end
            wdt_d = (wdt_active && !WDT_KICK) ? wdt_q + 1'b1 : '0;
        end
    end

    assign RST_OUT = rst_q;
    assign READY   = ready_q;
    assign CAUSE   = cause_q;

endmodule

// File: tb/tb_darksoc_rstseq.sv
// Bench for darksoc_rstseq: three parameterisations driven by shared inputs, compared every cycle
// against an edge-count model, plus directed release-timing, watchdog and restart scenarios.
module tb_darksoc_rstseq;

    logic       XCLK;
    logic       XRES;
    logic       SWRST_REQ;
    logic       WDT_EN;
    logic       WDT_KICK;
    logic [2:0] rst0;
    logic [7:0] rst1;
    logic [0:0] rst2;
    logic       ready0, ready1, ready2;
    logic [1:0] cause0, cause1, cause2;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-instance configuration and model state: edges since last trigger, cause, idle RUN edges.
    int cfg_n[3] = '{3, 8, 1};
    int cfg_h[3] = '{4, 1, 1};
    int cfg_s[3] = '{2, 1, 1};
    int cfg_l[3] = '{16, 0, 0};
    int m_n[3]     = '{0, 0, 0};
    int m_cause[3] = '{0, 0, 0};
    int m_wdt[3]   = '{0, 0, 0};

    darksoc_rstseq #(.NCH(3), .HOLD_CYCLES(4), .STAGGER(2), .WDT_LIMIT(16)) u_dut0 (
        .XCLK(XCLK), .XRES(XRES), .SWRST_REQ(SWRST_REQ), .WDT_EN(WDT_EN), .WDT_KICK(WDT_KICK),
        .RST_OUT(rst0), .READY(ready0), .CAUSE(cause0)
    );

    darksoc_rstseq #(.NCH(8), .HOLD_CYCLES(1), .STAGGER(1), .WDT_LIMIT(0)) u_dut1 (
        .XCLK(XCLK), .XRES(XRES), .SWRST_REQ(SWRST_REQ), .WDT_EN(WDT_EN), .WDT_KICK(WDT_KICK),
        .RST_OUT(rst1), .READY(ready1), .CAUSE(cause1)
    );

    darksoc_rstseq #(.NCH(1), .HOLD_CYCLES(1), .STAGGER(1), .WDT_LIMIT(0)) u_dut2 (
        .XCLK(XCLK), .XRES(XRES), .SWRST_REQ(SWRST_REQ), .WDT_EN(WDT_EN), .WDT_KICK(WDT_KICK),
        .RST_OUT(rst2), .READY(ready2), .CAUSE(cause2)
    );

    initial XCLK = 1'b0;
    always #5 XCLK = ~XCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic is_thermo(input logic [7:0] v, input int w);
        logic ok = 1'b1;
        logic seen_zero = 1'b0;
        for (int k = w - 1; k >= 0; k--) begin
            if (!v[k]) seen_zero = 1'b1;
            else if (seen_zero) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            int  last;
            bit  in_run;
            bit  timeout;
            last    = cfg_h[i] + (cfg_n[i] - 1) * cfg_s[i];
            in_run  = m_n[i] > last;
            timeout = (cfg_l[i] > 0) && in_run && WDT_EN && !WDT_KICK && (m_wdt[i] == cfg_l[i] - 1);
            if (XRES) begin
                m_n[i] = 0; m_cause[i] = 0; m_wdt[i] = 0;
            end else if (SWRST_REQ) begin
                m_n[i] = 0; m_cause[i] = 1; m_wdt[i] = 0;
            end else if (timeout) begin
                m_n[i] = 0; m_cause[i] = 2; m_wdt[i] = 0;
            end else begin
                m_n[i]++;
                m_wdt[i] = ((cfg_l[i] > 0) && in_run && WDT_EN && !WDT_KICK) ? m_wdt[i] + 1 : 0;
            end
        end
    endtask

    task automatic check_all();
        logic [7:0] act_rst[3];
        logic       act_rdy[3];
        logic [1:0] act_cause[3];
        act_rst[0] = {5'b0, rst0}; act_rst[1] = rst1; act_rst[2] = {7'b0, rst2};
        act_rdy[0] = ready0; act_rdy[1] = ready1; act_rdy[2] = ready2;
        act_cause[0] = cause0; act_cause[1] = cause1; act_cause[2] = cause2;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] exp_rst = '0;
            int         last = cfg_h[i] + (cfg_n[i] - 1) * cfg_s[i];
            for (int k = 0; k < cfg_n[i]; k++) exp_rst[k] = m_n[i] < cfg_h[i] + k * cfg_s[i];
            chk($sformatf("rst_out[%0d]", i), 32'(act_rst[i]), 32'(exp_rst));
            chk($sformatf("ready[%0d]", i), 32'(act_rdy[i]), 32'(m_n[i] > last));
            chk($sformatf("cause[%0d]", i), 32'(act_cause[i]), 32'(m_cause[i]));
            chk($sformatf("thermo[%0d]", i), 32'(is_thermo(act_rst[i], cfg_n[i])), 32'd1);
        end
    endtask

    task automatic step();
        @(posedge XCLK);
        model_edge();
        @(negedge XCLK);
        check_all();
    endtask

    task automatic step_n(input int c);
        for (int i = 0; i < c; i++) step();
    endtask

    // Advance until the instance-0 model watchdog count reaches target; expiry is a failure.
    task automatic wait_wdt(input int target, input string tag);
        int c = 0;
        while (m_wdt[0] != target && c < 60) begin
            step();
            c++;
        end
        chk(tag, 32'(m_wdt[0]), 32'(target));
    endtask

    initial begin
        int c;
        XRES = 1'b1; SWRST_REQ = 1'b0; WDT_EN = 1'b0; WDT_KICK = 1'b0;

        // Power-on reset and release timing
        step_n(2);
        chk("por_hold_rst", 32'(rst0), 32'h7);
        chk("por_hold_ready", 32'(ready0), 32'h0);
        XRES = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (e == 3) chk("por_e3", 32'(rst0), 32'h7);
            if (e == 4) chk("por_e4", 32'(rst0), 32'h6);
            if (e == 6) chk("por_e6", 32'(rst0), 32'h4);
            if (e == 8) begin
                chk("por_e8_rst", 32'(rst0), 32'h0);
                chk("por_e8_ready", 32'(ready0), 32'h0);
                chk("por8_e8_ready", 32'(ready1), 32'h0);
            end
            if (e == 9) begin
                chk("por_e9_ready", 32'(ready0), 32'h1);
                chk("por8_e9_ready", 32'(ready1), 32'h1);
                chk("por_cause", 32'(cause0), 32'h0);
            end
        end

        // Soft reset from RUN
        SWRST_REQ = 1'b1;
        step();
        SWRST_REQ = 1'b0;
        chk("soft_rst", 32'(rst0), 32'h7);
        chk("soft_ready", 32'(ready0), 32'h0);
        chk("soft_cause", 32'(cause0), 32'h1);
        for (int e = 1; e <= 9; e++) begin
            step();
            if (e == 4) chk("soft_e4", 32'(rst0), 32'h6);
            if (e == 8) chk("soft_e8_ready", 32'(ready0), 32'h0);
            if (e == 9) chk("soft_e9_ready", 32'(ready0), 32'h1);
        end

        // Unserviced watchdog fires on the 16th RUN edge
        WDT_EN = 1'b1;
        c = 0;
        while (ready0 && c < 60) begin
            step();
            c++;
        end
        chk("wdt_fire_cycle", 32'(c), 32'd16);
        chk("wdt_cause", 32'(cause0), 32'h2);
        chk("wdt_never_inst1", 32'(cause1), 32'h1);

        // Periodic kicks keep the system running
        c = 0;
        while (!ready0 && c < 20) begin
            step();
            c++;
        end
        chk("wdt_rerelease", 32'(ready0), 32'h1);
        for (int i = 0; i < 200; i++) begin
            WDT_KICK = (i % 10 == 0);
            step();
        end
        WDT_KICK = 1'b0;
        chk("kick_ready", 32'(ready0), 32'h1);

        // Kick exactly on the timeout edge
        wait_wdt(15, "wait_wdt_kick");
        WDT_KICK = 1'b1;
        step();
        WDT_KICK = 1'b0;
        chk("kick_on_timeout_ready", 32'(ready0), 32'h1);
        chk("kick_on_timeout_cause", 32'(cause0), 32'h2);

        // Soft reset and timeout on the same edge: soft wins
        wait_wdt(15, "wait_wdt_swrst");
        SWRST_REQ = 1'b1;
        step();
        chk("swrst_vs_wdt_cause", 32'(cause0), 32'h1);
        chk("swrst_vs_wdt_rst", 32'(rst0), 32'h7);

        // Held soft reset keeps the sequence at the start
        step_n(5);
        chk("swrst_held_rst", 32'(rst0), 32'h7);
        chk("swrst_held_ready", 32'(ready1), 32'h0);
        SWRST_REQ = 1'b0;
        step_n(4);
        chk("held_drop_e4", 32'(rst0), 32'h6);

        // Mid-sequence restarts
        step();
        chk("mid_e5", 32'(rst0), 32'h6);
        SWRST_REQ = 1'b1;
        step();
        SWRST_REQ = 1'b0;
        chk("mid_swrst", 32'(rst0), 32'h7);
        step_n(7);
        chk("mid_e7", 32'(rst0), 32'h4);
        XRES = 1'b1;
        step();
        XRES = 1'b0;
        chk("mid_xres_cause", 32'(cause0), 32'h0);
        chk("mid_xres_rst", 32'(rst1), 32'hff);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            XRES      = ($urandom_range(0, 299) == 0);
            SWRST_REQ = ($urandom_range(0, 149) == 0);
            WDT_EN    = ($urandom_range(0, 9) != 0);
            WDT_KICK  = ($urandom_range(0, 13) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
